// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder slice.
// Holds the FSM state encoding and the bus widths.
package mem_pkg;

    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 32;
    localparam int DEPTH_DEF = 512;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    function automatic logic addr_oob(
        input logic [ADDR_W-1:0] addr,
        input int                depth
    );
        return int'(addr) >= depth;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, DEPTH x DATA_W, registered read.
// Only the read register is reset; the storage keeps its contents.
module mem_array
    import mem_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // The read register holds its value across writes and idle cycles.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_en && !i_we) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: FSM, request latches, output flags.
// Define MEM_RESPONDER_BOUNDS_EN to flag addresses >= DEPTH via out_err.
module mem_responder
    import mem_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int DEPTH       = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              in_reset_n,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    output logic [DATA_W-1:0] out_rdata,
    output logic              out_ready,
    output logic              out_busy,
    output logic              out_err
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_ready;
    logic              r_busy;

    logic              w_oob;
    logic              w_en;
    logic [AW-1:0]     w_idx;
    logic [DATA_W-1:0] w_arr_rdata;

    assign w_idx = AW'(int'(r_addr) % DEPTH);

`ifdef MEM_RESPONDER_BOUNDS_EN
    assign w_oob = addr_oob(r_addr, DEPTH);
`else
    assign w_oob = 1'b0;
`endif

    assign w_en = (r_state == S_ACCESS) && !w_oob;

    always_ff @(posedge clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    // Write wins when both strobes are high.
                    if (in_mem_read || in_mem_write) begin
                        r_we    <= in_mem_write;
                        r_addr  <= in_addr;
                        r_wdata <= in_wdata;
                        r_cnt   <= WS_LOAD;
                        r_busy  <= 1'b1;
                        r_state <= (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_ACCESS;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACCESS: begin
                    r_state <= S_DONE;
                    r_ready <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .i_rst_n (in_reset_n),
        .i_en    (w_en),
        .i_we    (r_we),
        .i_addr  (w_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_arr_rdata)
    );

`ifdef MEM_RESPONDER_BOUNDS_EN
    logic r_err;
    logic r_rzero;

    // A rejected read masks the array output until the next good read.
    always_ff @(posedge clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_err   <= 1'b0;
            r_rzero <= 1'b0;
        end else if (r_state == S_ACCESS) begin
            r_err <= w_oob;
            if (!r_we) begin
                r_rzero <= w_oob;
            end
        end else if (r_state == S_DONE) begin
            r_err <= 1'b0;
        end
    end

    assign out_err   = r_err;
    assign out_rdata = r_rzero ? '0 : w_arr_rdata;
`else
    assign out_err   = 1'b0;
    assign out_rdata = w_arr_rdata;
`endif

    assign out_ready = r_ready;
    assign out_busy  = r_busy;

endmodule
